mem_arb2: RTL and testbench
===========================

# mem_arb2

Two-port arbiter that shares the single-port 256×8 data memory between the divisor-search engine (port A) and the host loader/readback (port B). It sequences every memory access: it selects one requester round-robin, drives the memory address, data, Rw and En lines, captures read data, and acknowledges the owner. It sits between the search datapath's Addr/Data/Rw/En pins and the memory macro.

## Interface
- A_WIDTH, 8, address width
- D_WIDTH, 8, data width
- LOCK_MAX, 4, maximum consecutive locked accesses by one owner (1..15)

- Clk  in  1  clock
- Rst  in  1  reset Rst, synchronous, active-high
- ReqA / ReqB  in  1  access request (level)
- RwA / RwB  in  1  0 = read, 1 = write
- AddrA / AddrB  in  A_WIDTH  access address
- WDataA / WDataB  in  D_WIDTH  write data
- LockA / LockB  in  1  keep ownership for the next access (only with ARB_LOCK_EN)
- GntA / GntB  out  1  high while that port owns the memory (ISSUE and COMPLETE)
- AckA / AckB  out  1  one-cycle pulse: access done, RData valid for reads
- RData  out  D_WIDTH  read data, held until the next read completes
- MemAddr  out  A_WIDTH  memory address
- MemWData  out  D_WIDTH  memory write data
- MemRData  in  D_WIDTH  memory read data, valid one cycle after MemEn
- MemRw  out  1  0 = read, 1 = write
- MemEn  out  1  memory enable

## Operation
- FSM states: IDLE, ISSUE, COMPLETE.
- IDLE:
  - If any Req is high, select the winner, register its Rw, Addr and WData, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - MemEn = 1; MemRw, MemAddr and MemWData come from the registered operands.
  - Owner's Gnt = 1.
  - Always go to COMPLETE.
- COMPLETE:
  - MemEn = 0; owner's Gnt = 1; owner's Ack = 1.
  - On a read, RData is loaded from MemRData at the end of this cycle, so RData is valid from the Ack cycle onward.
  - Candidates for the next access are the other port's Req, plus the owner's Req only if it is locked.
  - If there is a candidate, arbitrate and go straight to ISSUE; otherwise go to IDLE.
- Arbitration:
  - Round-robin on the LastOwner register. A tie goes to the port that is not LastOwner.
  - LastOwner resets to B, so A wins the first tie.
- Owner's Req is ignored during ISSUE and COMPLETE. The owner must drop Req in the cycle after Ack; Req still high then counts as a new request.
- Operands are sampled only at the transition into ISSUE. The requester may change them once Gnt is high.
- LockCnt (4-bit):
  - Incremented on each locked re-grant to the same owner.
  - Cleared on an ownership change or on entry to IDLE.
  - When LockCnt = LOCK_MAX−1, Lock is ignored. If the other port is requesting it wins; if not, the owner's next request goes through IDLE.
- Reset values: state IDLE; MemEn, MemRw, Gnt*, Ack* = 0; MemAddr, MemWData, RData = 0; LockCnt = 0; LastOwner = B.
- Reset mid-access: MemEn drops at the next edge and no Ack is issued. Requesters reissue after reset.

## Timing
- Request sampled high at edge n in IDLE:
  - cycle n+1: ISSUE, MemEn = 1, Gnt = 1
  - cycle n+2: COMPLETE, Ack = 1
  - RData valid from n+2
- Back-to-back accesses (alternating ports, or locked): one access every 2 cycles, with no IDLE cycle in between.
- Single requester without lock: one access every 3 cycles.
- Gnt, Ack and Mem* are registered outputs; there is no combinational path from Req to any output.

## Configuration
- ARB_LOCK_EN defined: Lock inputs are honoured as described above, bounded by LOCK_MAX.
- ARB_LOCK_EN undefined:
  - LockA and LockB are ignored and LockCnt is not implemented.
  - The owner is never a candidate in COMPLETE, giving strict alternation under contention.
  - Ports are unchanged.

## Test plan
- Reset with ReqA = 1 held → all outputs 0; state IDLE until Rst = 0; first Ack is AckA two cycles after the first sampling edge.
- Port B writes 0x5A to 0x10, then port A reads 0x10 → AckA with RData = 0x5A; MemRw = 1 during the write ISSUE cycle and 0 during the read ISSUE cycle.
- ReqA and ReqB raised together and held, each dropped after its Ack and re-raised one cycle later → grants A, B, A, B, ISSUE every 2 cycles, no IDLE in between.
- With ARB_LOCK_EN, LOCK_MAX = 4, LockA = 1, and ReqA and ReqB held continuously → A gets 4 consecutive accesses, then B gets 1, then A again. Without the macro → strict A/B alternation.
- Rst asserted in the ISSUE cycle of a port A write → no AckA; state IDLE; MemEn = 0 on the next cycle.
- Port A read at 0xFF, with the memory modelled at one-cycle latency → MemAddr = 0xFF and RData equals the memory contents at the Ack.

Source files
------------

// File: rtl/mem_arb2_if.sv
// Bus bundle for mem_arb2: both requester ports plus the memory macro pins.
// master = arbiter view, slave = requesters/memory view.
interface mem_arb2_if #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned D_WIDTH = 8
);
  logic               ReqA, ReqB;
  logic               RwA, RwB;
  logic [A_WIDTH-1:0] AddrA, AddrB;
  logic [D_WIDTH-1:0] WDataA, WDataB;
  logic               LockA, LockB;
  logic               GntA, GntB;
  logic               AckA, AckB;
  logic [D_WIDTH-1:0] RData;
  logic [A_WIDTH-1:0] MemAddr;
  logic [D_WIDTH-1:0] MemWData;
  logic [D_WIDTH-1:0] MemRData;
  logic               MemRw;
  logic               MemEn;

  modport master (
    input  ReqA, ReqB, RwA, RwB, AddrA, AddrB, WDataA, WDataB, LockA, LockB, MemRData,
    output GntA, GntB, AckA, AckB, RData, MemAddr, MemWData, MemRw, MemEn
  );

  modport slave (
    output ReqA, ReqB, RwA, RwB, AddrA, AddrB, WDataA, WDataB, LockA, LockB, MemRData,
    input  GntA, GntB, AckA, AckB, RData, MemAddr, MemWData, MemRw, MemEn
  );
endinterface

// File: rtl/mem_arb2.sv
// Round-robin two-port arbiter in front of a single-port data memory.
// Define ARB_LOCK_EN to honour LockA/LockB (bounded by LOCK_MAX consecutive accesses).
module mem_arb2 #(
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned D_WIDTH  = 8,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  mem_arb2_if.master bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  logic [1:0]         r_state;
  logic               r_last_b;  // LastOwner; also the current owner during ISSUE/COMPLETE
  logic               r_gnt_a, r_gnt_b, r_ack_a, r_ack_b;
  logic               r_mem_en, r_mem_rw;
  logic [A_WIDTH-1:0] r_mem_addr;
  logic [D_WIDTH-1:0] r_mem_wdata;
  logic [D_WIDTH-1:0] r_rdata;

  logic w_cand_a, w_cand_b, w_keep, w_win_b, w_go, w_lock_ok;

`ifdef ARB_LOCK_EN
  localparam logic [3:0] LockLast = 4'(LOCK_MAX - 1);
  logic [3:0] r_lock_cnt;
`endif

  always_comb begin
    w_lock_ok = 1'b0;
`ifdef ARB_LOCK_EN
    w_lock_ok = (r_lock_cnt != LockLast) && (r_last_b ? bus.LockB : bus.LockA);
`endif
    w_cand_a = 1'b0;
    w_cand_b = 1'b0;
    w_keep   = 1'b0;
    if (r_state == IDLE) begin
      w_cand_a = bus.ReqA;
      w_cand_b = bus.ReqB;
    end else if (r_state == COMPLETE) begin
      w_cand_a = r_last_b ? bus.ReqA : (bus.ReqA && w_lock_ok);
      w_cand_b = r_last_b ? (bus.ReqB && w_lock_ok) : bus.ReqB;
      w_keep   = w_lock_ok && (r_last_b ? bus.ReqB : bus.ReqA);
    end
    // A locked owner beats round-robin; otherwise a tie goes away from LastOwner.
    w_win_b = w_keep ? r_last_b : (w_cand_b && (!w_cand_a || !r_last_b));
    w_go    = w_cand_a || w_cand_b;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_last_b    <= 1'b1;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
`ifdef ARB_LOCK_EN
      r_lock_cnt  <= '0;
`endif
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      if (r_state == ISSUE) begin
        r_state  <= COMPLETE;
        r_mem_en <= 1'b0;
        r_ack_a  <= !r_last_b;
        r_ack_b  <= r_last_b;
      end else if (w_go) begin
        r_state     <= ISSUE;
        r_last_b    <= w_win_b;
        r_gnt_a     <= !w_win_b;
        r_gnt_b     <= w_win_b;
        r_mem_en    <= 1'b1;
        r_mem_rw    <= w_win_b ? bus.RwB : bus.RwA;
        r_mem_addr  <= w_win_b ? bus.AddrB : bus.AddrA;
        r_mem_wdata <= w_win_b ? bus.WDataB : bus.WDataA;
`ifdef ARB_LOCK_EN
        r_lock_cnt  <= (r_state == COMPLETE && w_win_b == r_last_b) ? r_lock_cnt + 4'd1 : 4'd0;
`endif
      end else begin
        r_state <= IDLE;
        r_gnt_a <= 1'b0;
        r_gnt_b <= 1'b0;
`ifdef ARB_LOCK_EN
        r_lock_cnt <= '0;
`endif
      end
      if (r_state == COMPLETE && !r_mem_rw) begin
        r_rdata <= bus.MemRData;
      end
    end
  end

  assign bus.GntA     = r_gnt_a;
  assign bus.GntB     = r_gnt_b;
  assign bus.AckA     = r_ack_a;
  assign bus.AckB     = r_ack_b;
  assign bus.MemEn    = r_mem_en;
  assign bus.MemRw    = r_mem_rw;
  assign bus.MemAddr  = r_mem_addr;
  assign bus.MemWData = r_mem_wdata;
  // Memory read data is passed straight through in the Ack cycle, then held.
  assign bus.RData    = (r_state == COMPLETE && !r_mem_rw) ? bus.MemRData : r_rdata;

endmodule

// File: tb/tb_mem_arb2.sv
// Directed self-checking bench for mem_arb2 with a one-cycle-latency memory model.
module tb_mem_arb2;
  logic Clk = 1'b0;
  logic Rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] mem [256];
  logic [5:0] seq;

  mem_arb2_if #(.A_WIDTH(8), .D_WIDTH(8)) bus ();

  mem_arb2 #(.A_WIDTH(8), .D_WIDTH(8), .LOCK_MAX(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (bus.MemEn) begin
      if (bus.MemRw) mem[bus.MemAddr] <= bus.MemWData;
      else           bus.MemRData     <= mem[bus.MemAddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic own_b, input logic phase);
    chk({tag, "_gnt"}, {bus.GntA, bus.GntB}, own_b ? 2'b01 : 2'b10);
    chk({tag, "_en"}, bus.MemEn, !phase);
    chk({tag, "_ack"}, {bus.AckA, bus.AckB}, phase ? (own_b ? 2'b01 : 2'b10) : 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[255] = 8'hC3;
    bus.MemRData = 8'h00;
    Rst = 1'b1;
    bus.ReqA = 1'b1; bus.ReqB = 1'b0; bus.RwA = 1'b0; bus.RwB = 1'b0;
    bus.AddrA = 8'h00; bus.AddrB = 8'h00; bus.WDataA = 8'h00; bus.WDataB = 8'h00;
    bus.LockA = 1'b0; bus.LockB = 1'b0;

    // Reset held with ReqA high
    repeat (3) @(negedge Clk);
    chk("rst_ctl", {bus.GntA, bus.GntB, bus.AckA, bus.AckB, bus.MemEn, bus.MemRw}, 6'b0);
    chk("rst_addr", bus.MemAddr, 8'h00);
    chk("rst_wdata", bus.MemWData, 8'h00);
    chk("rst_rdata", bus.RData, 8'h00);
    Rst = 1'b0;
    @(negedge Clk);
    chk_cycle("first_issue", 1'b0, 1'b0);
    bus.ReqA = 1'b0;
    @(negedge Clk);
    chk_cycle("first_cmpl", 1'b0, 1'b1);
    @(negedge Clk);
    chk("first_idle", {bus.GntA, bus.GntB, bus.AckA, bus.AckB, bus.MemEn}, 5'b0);

    // B writes 0x5A to 0x10, then A reads it back
    bus.ReqB = 1'b1; bus.RwB = 1'b1; bus.AddrB = 8'h10; bus.WDataB = 8'h5A;
    @(negedge Clk);
    chk_cycle("wr_issue", 1'b1, 1'b0);
    chk("wr_rw", bus.MemRw, 1'b1);
    chk("wr_addr", bus.MemAddr, 8'h10);
    chk("wr_wdata", bus.MemWData, 8'h5A);
    bus.ReqB = 1'b0; bus.AddrB = 8'hEE; bus.WDataB = 8'h00;
    @(negedge Clk);
    chk_cycle("wr_cmpl", 1'b1, 1'b1);
    bus.ReqA = 1'b1; bus.RwA = 1'b0; bus.AddrA = 8'h10;
    @(negedge Clk);
    chk_cycle("rd_issue", 1'b0, 1'b0);
    chk("rd_rw", bus.MemRw, 1'b0);
    chk("rd_addr", bus.MemAddr, 8'h10);
    bus.ReqA = 1'b0;
    @(negedge Clk);
    chk_cycle("rd_cmpl", 1'b0, 1'b1);
    chk("rd_data", bus.RData, 8'h5A);
    @(negedge Clk);
    chk("rd_hold", bus.RData, 8'h5A);

    // A reads the top address
    bus.ReqA = 1'b1; bus.AddrA = 8'hFF;
    @(negedge Clk);
    chk("ff_addr", bus.MemAddr, 8'hFF);
    bus.ReqA = 1'b0;
    @(negedge Clk);
    chk_cycle("ff_cmpl", 1'b0, 1'b1);
    chk("ff_data", bus.RData, 8'hC3);
    @(negedge Clk);

    // Reset during the ISSUE cycle of an A write
    bus.ReqA = 1'b1; bus.RwA = 1'b1; bus.AddrA = 8'h20; bus.WDataA = 8'h77;
    @(negedge Clk);
    chk("mid_en", bus.MemEn, 1'b1);
    Rst = 1'b1; bus.ReqA = 1'b0; bus.RwA = 1'b0;
    @(negedge Clk);
    chk("mid_rst", {bus.GntA, bus.AckA, bus.MemEn}, 3'b0);
    @(negedge Clk);
    chk("mid_noack", bus.AckA, 1'b0);

    // Contention without lock: A first, then strict alternation
    bus.ReqA = 1'b1; bus.ReqB = 1'b1;
    Rst = 1'b0;
    seq = 6'b101010;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk_cycle("alt", seq[i/2], i[0]);
    end

    // Contention with LockA held
    Rst = 1'b1; bus.LockA = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
`ifdef ARB_LOCK_EN
    seq = 6'b010000;
`else
    seq = 6'b101010;
`endif
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      chk_cycle("lock", seq[i/2], i[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
